// File: rtl/ddrphy_dll_update_sched_if.sv
// Bundle between the DLL update scheduler and its surroundings: requesters, periodic
// controls and the downstream update-controller handshake.
interface ddrphy_dll_update_sched_if #(
  parameter int NUM_REQ  = 3,
  parameter int PERIOD_W = 16
);
  localparam int ID_W = $clog2(NUM_REQ + 1);

  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic                idle_window;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  ack;
  logic                upd_req;
  logic                upd_ack;
  logic [ID_W-1:0]     grant_id;
  logic                busy;
  logic                timeout_err;

  // master is the PHY environment: requesters, CSR controls and the DLL update controller.
  modport master (
    output enable, period, idle_window, req, upd_ack,
    input  ack, upd_req, grant_id, busy, timeout_err
  );

  modport slave (
    input  enable, period, idle_window, req, upd_ack,
    output ack, upd_req, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/ddrphy_dll_update_sched.sv
// DLL update scheduler: round-robin over external requesters plus a periodic source,
// one update in flight, with a watchdog on the downstream req/ack handshake.
module ddrphy_dll_update_sched #(
  parameter int NUM_REQ  = 3,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic rclk,
  input  logic rst_n,
  ddrphy_dll_update_sched_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ + 1);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [ID_W-1:0]  PER_ID   = ID_W'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_DROP
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                upd_req_q;
  logic [ID_W-1:0]     grant_id_q;
  logic                busy_q;
  logic                timeout_err_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [TMR_W-1:0]    timer_q;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic                per_pend_q, per_pend_d;

  logic                grant_is_ext;
  logic [IDX_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  eligible;
  logic                arb_ext;
  logic [IDX_W-1:0]    arb_idx;
  logic [IDX_W-1:0]    cand;
  logic                per_done;

  assign grant_is_ext = (grant_id_q != PER_ID);
  assign grant_idx    = IDX_W'(grant_id_q);

  // A requester whose ack is still high has already been served and must not win again.
  assign eligible = bus.req & ~ack_q;

  // NOTE: every variable written in an always_comb gets a default on entry, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    arb_ext = 1'b0;
    arb_idx = '0;
    cand    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == LAST_IDX) begin
        cand = '0;
      end else begin
        cand = cand + 1'b1;
      end
      if (!arb_ext && eligible[cand]) begin
        arb_ext = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign per_done = (state_q == S_REQ) && bus.upd_ack && !grant_is_ext;

  // Periodic source: free-running interval counter feeding a single, non-accumulating flag.
  always_comb begin
    per_cnt_d  = per_cnt_q;
    per_pend_d = per_pend_q;
    if (per_done) begin
      per_pend_d = 1'b0;
    end
    if (!bus.enable || (bus.period == '0)) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == (bus.period - PERIOD_W'(1))) begin
      per_cnt_d  = '0;
      per_pend_d = 1'b1;
    end else begin
      per_cnt_d = per_cnt_q + PERIOD_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ack_q         <= '0;
      upd_req_q     <= 1'b0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= LAST_IDX;
      timer_q       <= '0;
      per_cnt_q     <= '0;
      per_pend_q    <= 1'b0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      per_pend_q <= per_pend_d;

      case (state_q)
        S_IDLE: begin
          if (bus.enable && (arb_ext || (per_pend_q && bus.idle_window))) begin
            state_q   <= S_REQ;
            busy_q    <= 1'b1;
            upd_req_q <= 1'b1;
            timer_q   <= '0;
            if (arb_ext) begin
              rr_ptr_q   <= arb_idx;
              grant_id_q <= ID_W'(arb_idx);
            end else begin
              grant_id_q <= PER_ID;
            end
          end
        end

        S_REQ: begin
          if (bus.upd_ack) begin
            state_q   <= S_ACK;
            upd_req_q <= 1'b0;
            if (grant_is_ext) begin
              ack_q[grant_idx] <= 1'b1;
            end
          end else if (timer_q == TMR_LAST) begin
            state_q       <= S_DROP;
            upd_req_q     <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        // Four-phase close: the controller must release upd_ack and, for an external
        // grant, the requester must release its req before the next arbitration.
        S_ACK: begin
          if (!bus.upd_ack && (!grant_is_ext || !bus.req[grant_idx])) begin
            state_q <= S_IDLE;
            ack_q   <= '0;
            busy_q  <= 1'b0;
          end
        end

        // Timed-out transaction: no ack, the requester keeps req high and re-arbitrates.
        S_DROP: begin
          if (!bus.upd_ack) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          ack_q     <= '0;
          upd_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.upd_req     = upd_req_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
